// File: rtl/tone_pkg.sv
// Shared note codes, note frequencies and the tone half-period helper
// used by the tone sequencer and its tone generator.
package tone_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_e;

    typedef enum logic [3:0] {
        REST = 4'd0,
        DO   = 4'd1,
        RE   = 4'd2,
        MI   = 4'd3,
        FA   = 4'd4,
        SOL  = 4'd5,
        LA   = 4'd6,
        SI   = 4'd7,
        DO2  = 4'd8
    } note_e;

    localparam int unsigned F_DO  = 262;
    localparam int unsigned F_RE  = 294;
    localparam int unsigned F_MI  = 330;
    localparam int unsigned F_FA  = 349;
    localparam int unsigned F_SOL = 392;
    localparam int unsigned F_LA  = 440;
    localparam int unsigned F_SI  = 494;
    localparam int unsigned F_DO2 = 523;

    // Clocks per half period of a note; 0 marks a rest, real notes never go below 1.
    function automatic int unsigned half_period(input logic [3:0] code, input int unsigned clk_hz);
        int unsigned f;
        int unsigned h;
        case (code)
            DO:      f = F_DO;
            RE:      f = F_RE;
            MI:      f = F_MI;
            FA:      f = F_FA;
            SOL:     f = F_SOL;
            LA:      f = F_LA;
            SI:      f = F_SI;
            DO2:     f = F_DO2;
            default: f = 0;
        endcase
        if (f == 0) begin
            return 0;
        end
        h = clk_hz / (2 * f);
        return (h == 0) ? 1 : h;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Shared square-wave divider: restarts at phase 0 on every load and
// toggles sq every `half` enabled cycles.
module tone_gen #(
    parameter int unsigned HALF_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [HALF_W-1:0] half,
    input  logic              en,
    output logic              sq
);

    logic [HALF_W-1:0] half_q, half_d;
    logic [HALF_W-1:0] cnt_q, cnt_d;
    logic              sq_q, sq_d;

    always_comb begin
        half_d = half_q;
        cnt_d  = cnt_q;
        sq_d   = sq_q;
        if (load) begin
            half_d = half;
            sq_d   = 1'b0;
            cnt_d  = (half == '0) ? '0 : half - 1'b1;
        end else if (en) begin
            if (cnt_q == '0) begin
                sq_d  = ~sq_q;
                cnt_d = (half_q == '0) ? '0 : half_q - 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            half_q <= '0;
            cnt_q  <= '0;
            sq_q   <= 1'b0;
        end else begin
            half_q <= half_d;
            cnt_q  <= cnt_d;
            sq_q   <= sq_d;
        end
    end

    assign sq = sq_q;

endmodule

// File: rtl/tone_sequencer.sv
// Song player: steps through a loadable note RAM at a fixed tempo and
// drives one speaker bit from a single shared tone divider.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 25000000,
    parameter int unsigned BEAT_CYCLES = 10000000,
    parameter int unsigned SONG_LEN    = 48,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned NOTE_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [NOTE_W-1:0] wr_data,
    output logic              speaker,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] step
);

    localparam int unsigned BEAT_W   = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int unsigned HALF_MAX = half_period(DO, CLK_HZ);
    localparam int unsigned HALF_W   = $clog2(HALF_MAX + 1);
    localparam int unsigned N_CODES  = 2 ** NOTE_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   step_q, step_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [NOTE_W-1:0]   cur_note_q, cur_note_d;
    logic                done_q, done_d;
    logic                load;
    logic [ADDR_W-1:0]   load_addr;
    logic [NOTE_W-1:0]   rd_note;
    logic                is_note;
    logic                sq;

    logic [NOTE_W-1:0]   mem [2**ADDR_W];
    logic [HALF_W-1:0]   half_lut [N_CODES];

    // Half periods are elaboration-time constants; codes above DO2 fold to rest.
    for (genvar g = 0; g < N_CODES; g++) begin : g_half_lut
        assign half_lut[g] = HALF_W'(half_period((g <= 8) ? 4'(g) : 4'(REST), CLK_HZ));
    end

    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < (ADDR_W + 1)'(SONG_LEN))) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Combinational read ahead of the write port gives read-before-write on collisions.
    assign rd_note    = mem[load_addr];
    assign cur_note_d = load ? rd_note : cur_note_q;

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        beat_d    = beat_q;
        done_d    = 1'b0;
        load      = 1'b0;
        load_addr = '0;
        case (state_q)
            IDLE: begin
                step_d = '0;
                if (start && !stop) begin
                    state_d = PLAY;
                    beat_d  = '0;
                    load    = 1'b1;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                    step_d  = '0;
                    beat_d  = '0;
                end else if (start) begin
                    step_d = '0;
                    beat_d = '0;
                    load   = 1'b1;
                end else if (beat_q == BEAT_W'(BEAT_CYCLES - 1)) begin
                    beat_d = '0;
                    if (step_q < ADDR_W'(SONG_LEN - 1)) begin
                        step_d    = step_q + 1'b1;
                        load      = 1'b1;
                        load_addr = step_q + 1'b1;
                    end else if (loop) begin
                        step_d = '0;
                        load   = 1'b1;
                    end else begin
                        state_d = IDLE;
                        step_d  = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            step_q     <= '0;
            beat_q     <= '0;
            cur_note_q <= NOTE_W'(REST);
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            beat_q     <= beat_d;
            cur_note_q <= cur_note_d;
            done_q     <= done_d;
        end
    end

    assign is_note = (half_lut[cur_note_q] != '0);

    tone_gen #(
        .HALF_W (HALF_W)
    ) u_tone_gen (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .half (half_lut[rd_note]),
        .en   ((state_q == PLAY) && is_note),
        .sq   (sq)
    );

    assign busy    = (state_q == PLAY);
    assign speaker = sq && busy && is_note;
    assign done    = done_q;
    assign step    = step_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Randomised and directed bench for tone_sequencer against a
// time-based behavioural model of the player.
module tb_tone_sequencer;

    localparam int CLK_HZ = 2620;
    localparam int BC     = 20;
    localparam int SL     = 4;
    localparam int AW     = 3;
    localparam int NW     = 4;

    logic          clk = 1'b0;
    logic          rst, start, stop, loop_i, wr_en;
    logic [AW-1:0] wr_addr;
    logic [NW-1:0] wr_data;
    logic          speaker, busy, done;
    logic [AW-1:0] step;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: song memory, whether playing, current step, cycles elapsed in step, note sounding.
    int m_mem [SL];
    bit m_play;
    bit m_done;
    int m_step, m_elapsed, m_note;

    tone_sequencer #(
        .CLK_HZ(CLK_HZ), .BEAT_CYCLES(BC), .SONG_LEN(SL), .ADDR_W(AW), .NOTE_W(NW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop_i),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .speaker(speaker), .busy(busy), .done(done), .step(step)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int exp_half(int code);
        int f;
        int h;
        case (code)
            1: f = 262;  2: f = 294;  3: f = 330;  4: f = 349;
            5: f = 392;  6: f = 440;  7: f = 494;  8: f = 523;
            default: f = 0;
        endcase
        if (f == 0) return 0;
        h = CLK_HZ / (2 * f);
        return (h < 1) ? 1 : h;
    endfunction

    // Square wave starts low at the note load and flips every HALF cycles.
    function automatic bit exp_spk();
        int h;
        h = exp_half(m_note);
        if (!m_play || h == 0) return 1'b0;
        return ((m_elapsed / h) % 2) == 1;
    endfunction

    function automatic void begin_step(int s);
        m_play    = 1'b1;
        m_step    = s;
        m_elapsed = 0;
        m_note    = m_mem[s];
    endfunction

    function automatic void model_update();
        m_done = 1'b0;
        if (rst) begin
            m_play = 1'b0; m_step = 0; m_elapsed = 0; m_note = 0;
        end else if (m_play) begin
            if (stop) begin
                m_play = 1'b0; m_step = 0;
            end else if (start) begin
                begin_step(0);
            end else if (m_elapsed == BC - 1) begin
                if (m_step < SL - 1)  begin_step(m_step + 1);
                else if (loop_i)      begin_step(0);
                else begin
                    m_play = 1'b0; m_step = 0; m_done = 1'b1;
                end
            end else begin
                m_elapsed++;
            end
        end else if (start && !stop) begin
            begin_step(0);
        end
        if (wr_en && int'(wr_addr) < SL) m_mem[wr_addr] = int'(wr_data);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic write_note(int a, int d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = NW'(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_i = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        tick(); tick();
        n_cmp++;
        if ({speaker, busy, done, step} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset: got spk=%b busy=%b done=%b step=%0d want all 0", speaker, busy, done, step);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_oneshot(string tag);
        int rises[8];
        int busy_n, done_n;
        bit prev;
        foreach (rises[i]) rises[i] = 0;
        busy_n = 0; done_n = 0; prev = 1'b0;
        loop_i = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 90; c++) begin
            n_cmp++;
            if ({speaker, busy, done, step} !== {exp_spk(), m_play, m_done, AW'(m_step)}) begin
                n_fail++;
                $display("FAIL %s c%0d: got spk=%b busy=%b done=%b step=%0d want %b %b %b %0d",
                         tag, c, speaker, busy, done, step, exp_spk(), m_play, m_done, m_step);
            end
            if (busy === 1'b1 && speaker === 1'b1 && !prev) rises[step]++;
            prev = (speaker === 1'b1);
            busy_n += (busy === 1'b1) ? 1 : 0;
            done_n += (done === 1'b1) ? 1 : 0;
            tick();
        end
        n_cmp++;
        if (busy_n !== 80) begin n_fail++; $display("FAIL %s busy_len: got %0d want 80", tag, busy_n); end
        n_cmp++;
        if (done_n !== 1) begin n_fail++; $display("FAIL %s done_count: got %0d want 1", tag, done_n); end
        n_cmp++;
        if ({rises[0], rises[1], rises[2], rises[3]} !== {32'd2, 32'd2, 32'd0, 32'd5}) begin
            n_fail++;
            $display("FAIL %s rises: got %0d %0d %0d %0d want 2 2 0 5", tag, rises[0], rises[1], rises[2], rises[3]);
        end
        n_cmp++;
        if ({busy, step, speaker} !== 5'b0) begin
            n_fail++; $display("FAIL %s end_idle: got busy=%b step=%0d spk=%b want 0", tag, busy, step, speaker);
        end
    endtask

    task automatic test_loop();
        int done_n, wrap_c, rise_c;
        logic [AW-1:0] prev_step;
        done_n = 0; wrap_c = -1; rise_c = -1; prev_step = '0;
        loop_i = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 120; c++) begin
            n_cmp++;
            if ({speaker, busy, done, step} !== {exp_spk(), m_play, m_done, AW'(m_step)}) begin
                n_fail++;
                $display("FAIL loop c%0d: got spk=%b busy=%b done=%b step=%0d want %b %b %b %0d",
                         c, speaker, busy, done, step, exp_spk(), m_play, m_done, m_step);
            end
            if (prev_step == AW'(3) && step === '0 && wrap_c < 0) wrap_c = c;
            if (wrap_c >= 0 && rise_c < 0 && speaker === 1'b1) rise_c = c;
            prev_step = step;
            done_n += (done === 1'b1) ? 1 : 0;
            tick();
        end
        n_cmp++;
        if (done_n !== 0) begin n_fail++; $display("FAIL loop done_count: got %0d want 0", done_n); end
        n_cmp++;
        if (wrap_c < 0 || rise_c - wrap_c !== 5) begin
            n_fail++; $display("FAIL loop wrap_phase: got wrap=%0d rise=%0d want rise-wrap=5", wrap_c, rise_c);
        end
        stop = 1'b1; tick(); stop = 1'b0;
        loop_i = 1'b0;
    endtask

    task automatic test_stop();
        int done_n;
        done_n = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 30; c++) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        n_cmp++;
        if ({speaker, busy, done, step} !== 6'b0) begin
            n_fail++;
            $display("FAIL stop: got spk=%b busy=%b done=%b step=%0d want all 0", speaker, busy, done, step);
        end
        for (int c = 0; c < 80; c++) begin
            done_n += (done === 1'b1) ? 1 : 0;
            tick();
        end
        n_cmp++;
        if (done_n !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL stop_after: got done_count=%0d busy=%b want 0 0", done_n, busy);
        end
    endtask

    task automatic test_start_stop();
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL both_idle: got busy=%b want 0", busy); end
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 25; c++) tick();
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        n_cmp++;
        if ({busy, step} !== 4'b0) begin
            n_fail++; $display("FAIL both_play: got busy=%b step=%0d want 0 0", busy, step);
        end
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 30; c++) tick();
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++;
        if ({busy, step, speaker} !== {1'b1, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL restart: got busy=%b step=%0d spk=%b want 1 0 0", busy, step, speaker);
        end
        for (int c = 0; c < 4; c++) tick();
        n_cmp++;
        if (speaker !== 1'b0) begin n_fail++; $display("FAIL restart_u4: got spk=%b want 0", speaker); end
        tick();
        n_cmp++;
        if (speaker !== 1'b1) begin n_fail++; $display("FAIL restart_u5: got spk=%b want 1", speaker); end
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic test_write_during_play();
        int pass_rises[3];
        int pass;
        bit prev;
        logic [AW-1:0] prev_step;
        foreach (pass_rises[i]) pass_rises[i] = 0;
        pass = -1; prev = 1'b0; prev_step = '0;
        loop_i = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 190; c++) begin
            n_cmp++;
            if ({speaker, busy, done, step} !== {exp_spk(), m_play, m_done, AW'(m_step)}) begin
                n_fail++;
                $display("FAIL wr c%0d: got spk=%b busy=%b done=%b step=%0d want %b %b %b %0d",
                         c, speaker, busy, done, step, exp_spk(), m_play, m_done, m_step);
            end
            if (step === AW'(1) && prev_step !== AW'(1) && pass < 2) pass++;
            if (step === AW'(1) && pass >= 0 && speaker === 1'b1 && !prev) pass_rises[pass]++;
            prev = (speaker === 1'b1);
            prev_step = step;
            wr_en   = (c == 25 || c == 26);
            wr_addr = (c == 25) ? AW'(1) : AW'(7);
            wr_data = (c == 25) ? NW'(5) : NW'(3);
            tick();
        end
        wr_en = 1'b0;
        n_cmp++;
        if (pass_rises[0] !== 2 || pass_rises[1] !== 3) begin
            n_fail++; $display("FAIL wr_rises: got %0d %0d want 2 3", pass_rises[0], pass_rises[1]);
        end
        stop = 1'b1; tick(); stop = 1'b0;
        loop_i = 1'b0;
        write_note(1, 2);
    endtask

    task automatic test_rst_mid_note();
        int waited;
        waited = 0;
        start = 1'b1; tick(); start = 1'b0;
        while (speaker !== 1'b1 && waited < 40) begin tick(); waited++; end
        n_cmp++;
        if (speaker !== 1'b1) begin n_fail++; $display("FAIL rst_wait: got spk=%b want 1 within 40 cycles", speaker); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++;
        if ({speaker, busy, done, step} !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got spk=%b busy=%b done=%b step=%0d want all 0", speaker, busy, done, step);
        end
        tick();
        test_oneshot("replay");
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst     = ($urandom_range(0, 499) == 0);
            start   = ($urandom_range(0, 39) == 0);
            stop    = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 99) == 0) loop_i = ~loop_i;
            wr_en   = ($urandom_range(0, 9) == 0);
            wr_addr = AW'($urandom_range(0, 7));
            wr_data = NW'($urandom_range(0, 15));
            tick();
            n_cmp++;
            if ({speaker, busy, done, step} !== {exp_spk(), m_play, m_done, AW'(m_step)}) begin
                n_fail++;
                $display("FAIL rand c%0d: got spk=%b busy=%b done=%b step=%0d want %b %b %b %0d",
                         c, speaker, busy, done, step, exp_spk(), m_play, m_done, m_step);
            end
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        foreach (m_mem[i]) m_mem[i] = 0;
        m_play = 1'b0; m_done = 1'b0; m_step = 0; m_elapsed = 0; m_note = 0;
        test_reset();
        write_note(0, 1); write_note(1, 2); write_note(2, 0); write_note(3, 8);
        test_oneshot("oneshot");
        test_loop();
        test_stop();
        test_start_stop();
        test_write_during_play();
        test_rst_mid_note();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
